// File: rtl/defines_pkg.sv
// defines_pkg: shared types and limits for the memory blocks
package defines_pkg;
  typedef enum logic {MEM_INIT, MEM_READY} mem_init_state_t;
  localparam int MEM_MAX_RD_LAT = 2;
endpackage

// File: rtl/memory_bank.sv
// memory_bank: byte-enabled storage array, sync write, combinational read
// ports: clk; we/waddr/be/din write port; raddr/dout combinational read port
import defines_pkg::*;
module memory_bank #(
  parameter int WIDTH = 16,
  parameter int SIZE = 64,
  parameter int LSIZE = $clog2(SIZE)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [LSIZE-1:0]   waddr,
  input  logic [WIDTH/8-1:0] be,
  input  logic [WIDTH-1:0]   din,
  input  logic [LSIZE-1:0]   raddr,
  output logic [WIDTH-1:0]   dout
);
  logic [WIDTH-1:0] mem [SIZE];
  always_ff @(posedge clk)
    for (int i = 0; i < WIDTH/8; i++)
      if (we && be[i]) mem[waddr][8*i +: 8] <= din[8*i +: 8];
  assign dout = mem[raddr];
endmodule

// File: rtl/memory_2p_init.sv
// memory_2p_init: simple dual-port RAM with byte enables, bypass, pipelined read and init sweep
// ports: clk, rst_n (async, low); clear_req starts a re-init sweep;
//        wr_en/wr_addr/wr_be/data_in write port; rd_en/rd_addr read request;
//        data_out/rd_valid read response after RD_LAT cycles; ready high when idle-usable
import defines_pkg::*;
module memory_2p_init #(
  parameter int WIDTH = 16,
  parameter int SIZE = 64,
  parameter int LSIZE = $clog2(SIZE),
  parameter int RD_LAT = 1,
  parameter int BYPASS = 1,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_req,
  input  logic               wr_en,
  input  logic [LSIZE-1:0]   wr_addr,
  input  logic [WIDTH/8-1:0] wr_be,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               rd_en,
  input  logic [LSIZE-1:0]   rd_addr,
  output logic [WIDTH-1:0]   data_out,
  output logic               rd_valid,
  output logic               ready
);
  if (RD_LAT < 1 || RD_LAT > MEM_MAX_RD_LAT) begin : g_bad_lat
    $error("memory_2p_init: RD_LAT must be 1 or 2");
  end
  if (WIDTH % 8 != 0) begin : g_bad_width
    $error("memory_2p_init: WIDTH must be a multiple of 8");
  end
  mem_init_state_t state, state_d;
  logic [LSIZE-1:0] init_addr, init_addr_d, bank_waddr;
  logic [WIDTH/8-1:0] bank_be;
  logic [WIDTH-1:0] bank_din, old, mask, rd_word, d1, d2;
  logic wr_in, rd_in, wr_acc, rd_acc, bank_we, v1, v2;
  assign ready = state == MEM_READY;
  // addresses beyond SIZE only exist when SIZE is not a power of two
  assign wr_in = {1'b0, wr_addr} < (LSIZE+1)'(SIZE);
  assign rd_in = {1'b0, rd_addr} < (LSIZE+1)'(SIZE);
  // clear_req wins over a same-cycle user access
  assign wr_acc = ready && wr_en && !clear_req && wr_in;
  assign rd_acc = ready && rd_en && !clear_req;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= MEM_INIT;
      init_addr <= '0;
    end else begin
      state <= state_d;
      init_addr <= init_addr_d;
    end
  always_comb begin
    state_d = state;
    init_addr_d = init_addr;
    if (state == MEM_INIT) begin
      init_addr_d = init_addr + 1'b1;
      if (init_addr == LSIZE'(SIZE-1)) begin
        state_d = MEM_READY;
        init_addr_d = '0;
      end
    end else if (clear_req) begin
      state_d = MEM_INIT;
      init_addr_d = '0;
    end
  end
  // the sweep owns the write port for the whole INIT phase
  assign bank_we    = !ready || wr_acc;
  assign bank_waddr = ready ? wr_addr : init_addr;
  assign bank_be    = ready ? wr_be : '1;
  assign bank_din   = ready ? data_in : INIT_VAL;
  memory_bank #(.WIDTH(WIDTH), .SIZE(SIZE), .LSIZE(LSIZE)) u_bank (
    .clk(clk),
    .we(bank_we),
    .waddr(bank_waddr),
    .be(bank_be),
    .din(bank_din),
    .raddr(rd_addr),
    .dout(old)
  );
  always_comb begin
    mask = '0;
    for (int i = 0; i < WIDTH/8; i++) mask[8*i +: 8] = {8{wr_be[i]}};
  end
  assign rd_word = !rd_in ? INIT_VAL :
                   (BYPASS != 0 && wr_acc && wr_addr == rd_addr) ? (old & ~mask) | (data_in & mask) : old;
  // data registers only load on a valid so data_out holds between strobes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      d1 <= '0;
      d2 <= '0;
    end else begin
      v1 <= rd_acc;
      v2 <= v1;
      if (rd_acc) d1 <= rd_word;
      if (v1) d2 <= d1;
    end
  assign rd_valid = RD_LAT == 2 ? v2 : v1;
  assign data_out = RD_LAT == 2 ? d2 : d1;
endmodule
